// File: rtl/gray_seq_counter.sv
// Parametrised Gray-coded sequence counter.
// Binary state with registered Gray mirror, load, up/down, wrap or saturate.
module gray_seq_counter #(
  parameter int WIDTH       = 2,
  parameter bit SATURATE    = 1'b0,
  parameter int RESET_VALUE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             hold,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] gray_q,
  output logic [WIDTH-1:0] bin_q,
  output logic             wrap,
  output logic             sat,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] nxt;
  logic             nxt_wrap;
  logic             nxt_sat;
  logic             edge_hit;

  assign edge_hit = up ? (cnt == MAX) : (cnt == '0);

  always_comb begin
    nxt      = cnt;
    nxt_wrap = 1'b0;
    nxt_sat  = 1'b0;
    if (load) begin
      nxt = load_value;
    end else if (!hold) begin
      if (edge_hit && SATURATE) begin
        nxt_sat = 1'b1;
      end else begin
        nxt      = up ? cnt + 1'b1 : cnt - 1'b1;
        nxt_wrap = edge_hit;
      end
    end
  end

  // Gray is registered from the next binary value, so it never glitches.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt    <= RST;
      gray_q <= RST ^ (RST >> 1);
      wrap   <= 1'b0;
      sat    <= 1'b0;
    end else begin
      cnt    <= nxt;
      gray_q <= nxt ^ (nxt >> 1);
      wrap   <= nxt_wrap;
      sat    <= nxt_sat;
    end
  end

  assign bin_q  = cnt;
  assign at_max = (cnt == MAX);
  assign at_min = (cnt == '0);

endmodule

// File: tb/tb_gray_seq_counter.sv
// Directed and soak checks for gray_seq_counter.
// Several parameterisations share one set of control inputs.
module tb_gray_seq_counter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        hold  = 1'b0;
  logic        up    = 1'b0;
  logic        load  = 1'b0;
  logic [15:0] lv    = '0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  logic [1:0] g2, b2;
  logic [3:0] g4w, b4w, g4s, b4s;
  logic [2:0] g3, b3;
  logic [7:0] g8, b8;
  logic w2, s2, mx2, mn2;
  logic w4w, s4w, mx4w, mn4w;
  logic w4s, s4s, mx4s, mn4s;
  logic w3, s3, mx3, mn3;
  logic w8, s8, mx8, mn8;

  gray_seq_counter #(.WIDTH(2)) u2 (
    .clock(clock), .reset(reset), .hold(hold), .up(up),
    .load(load), .load_value(lv[1:0]),
    .gray_q(g2), .bin_q(b2), .wrap(w2), .sat(s2),
    .at_max(mx2), .at_min(mn2));

  gray_seq_counter #(.WIDTH(4)) u4w (
    .clock(clock), .reset(reset), .hold(hold), .up(up),
    .load(load), .load_value(lv[3:0]),
    .gray_q(g4w), .bin_q(b4w), .wrap(w4w), .sat(s4w),
    .at_max(mx4w), .at_min(mn4w));

  gray_seq_counter #(.WIDTH(4), .SATURATE(1'b1)) u4s (
    .clock(clock), .reset(reset), .hold(hold), .up(up),
    .load(load), .load_value(lv[3:0]),
    .gray_q(g4s), .bin_q(b4s), .wrap(w4s), .sat(s4s),
    .at_max(mx4s), .at_min(mn4s));

  gray_seq_counter #(.WIDTH(3)) u3 (
    .clock(clock), .reset(reset), .hold(hold), .up(up),
    .load(load), .load_value(lv[2:0]),
    .gray_q(g3), .bin_q(b3), .wrap(w3), .sat(s3),
    .at_max(mx3), .at_min(mn3));

  gray_seq_counter #(.WIDTH(8), .RESET_VALUE(8'h5A)) u8 (
    .clock(clock), .reset(reset), .hold(hold), .up(up),
    .load(load), .load_value(lv[7:0]),
    .gray_q(g8), .bin_q(b8), .wrap(w8), .sat(s8),
    .at_max(mx8), .at_min(mn8));

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [1:0] leg_g [5] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10};
  logic       leg_w [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [3:0] up_b  [3] = '{4'd15, 4'd0, 4'd1};
  logic [3:0] up_g  [3] = '{4'b1000, 4'b0000, 4'b0001};
  logic       up_w  [3] = '{1'b0, 1'b1, 1'b0};
  logic       st_s  [3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    logic [3:0] pg;
    logic [7:0] m, pg8;
    logic       mw, r, l, h, u;
    logic [7:0] v;

    // reset
    reset = 1'b1; hold = 1'b0; up = 1'b0;
    tick(); tick();
    check("rst_gray", 32'(g2), 32'h0);
    check("rst_bin", 32'(b2), 32'h0);
    check("rst_wrap", 32'(w2), 32'h0);
    check("rst_sat", 32'(s2), 32'h0);
    check("rst_min", 32'(mn2), 32'h1);
    check("rst_val8", 32'(b8), 32'h5A);

    // legacy sequence and hold
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("leg_gray", 32'(g2), 32'(leg_g[i]));
      check("leg_wrap", 32'(w2), 32'(leg_w[i]));
    end
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_gray", 32'(g2), 32'h2);
      check("hold_wrap", 32'(w2), 32'h0);
    end

    // wrap upward
    hold = 1'b0; load = 1'b1; lv = 16'd14;
    tick();
    check("ld_bin", 32'(b4w), 32'd14);
    check("ld_gray", 32'(g4w), 32'b1001);
    load = 1'b0; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pg = g4w;
      tick();
      check("up_bin", 32'(b4w), 32'(up_b[i]));
      check("up_gray", 32'(g4w), 32'(up_g[i]));
      check("up_wrap", 32'(w4w), 32'(up_w[i]));
      check("up_1bit", $countones(pg ^ g4w), 32'd1);
      if (i == 0) check("up_max", 32'(mx4w), 32'h1);
    end

    // saturate at zero, then recover
    load = 1'b1; lv = 16'd1;
    tick();
    load = 1'b0; up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_bin", 32'(b4s), 32'd0);
      check("sat_sat", 32'(s4s), 32'(st_s[i]));
      check("sat_wrap", 32'(w4s), 32'h0);
    end
    up = 1'b1;
    tick();
    check("sat_up_bin", 32'(b4s), 32'd1);
    check("sat_up_sat", 32'(s4s), 32'h0);

    // priority
    load = 1'b1; lv = 16'd5; up = 1'b0;
    tick();
    check("pri_pre", 32'(b3), 32'd5);
    lv = 16'd2; hold = 1'b1; up = 1'b1;
    tick();
    check("pri_ld_bin", 32'(b3), 32'd2);
    check("pri_ld_gray", 32'(g3), 32'b011);
    reset = 1'b1; lv = 16'd6;
    tick();
    check("pri_rst", 32'(b3), 32'd0);
    reset = 1'b0; load = 1'b0; hold = 1'b0;
    tick();
    check("pri_post", 32'(b3), 32'd1);

    // random soak on the 8-bit instance
    reset = 1'b1;
    tick();
    m = 8'h5A;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 31) == 0);
      l = ($urandom_range(0, 15) == 0);
      h = ($urandom_range(0, 3) == 0);
      u = 1'($urandom);
      v = 8'($urandom);
      reset = r; load = l; hold = h; up = u; lv = 16'(v);
      pg8 = g8;
      mw = 1'b0;
      if (r) m = 8'h5A;
      else if (l) m = v;
      else if (h) m = m;
      else if (u) begin mw = (m == 8'hFF); m = m + 8'd1; end
      else begin mw = (m == 8'h00); m = m - 8'd1; end
      tick();
      check("soak_bin", 32'(b8), 32'(m));
      check("soak_gray", 32'(g8), 32'(m ^ (m >> 1)));
      check("soak_wrap", 32'(w8), 32'(mw));
      if (!r && !l && !h)
        check("soak_1bit", $countones(pg8 ^ g8), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
